// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the two-master memory port arbiter.
// Signal names carry the arbiter's point of view: _i enters the arbiter,
// _o leaves it. The arbiter binds to "slave"; the surrounding system
// (requesters plus memory) binds to "master".
//
// Handshake: a requester raises rd/we with stable addr/data and holds them
// until its ack pulse; it drops the request in the following cycle. The
// memory sees a strobe (rd_o/we_o) held until it returns a one-cycle ack_i.
interface mem_port_arbiter_if;
   logic [31:0]  c_addr_i;
   logic [255:0] c_data_i;
   logic [255:0] c_data_o;
   logic         c_we_i;
   logic         c_rd_i;
   logic         c_ack_o;
   logic [31:0]  d_addr_i;
   logic [255:0] d_data_i;
   logic [255:0] d_data_o;
   logic         d_we_i;
   logic         d_rd_i;
   logic         d_urgent_i;
   logic         d_ack_o;
   logic         err_o;
   logic [1:0]   grant_o;
   logic [31:0]  addr_o;
   logic [255:0] data_o;
   logic [255:0] data_i;
   logic         we_o;
   logic         rd_o;
   logic         ack_i;
   logic [1:0]   state_o;   // arbiter FSM state, for observation only

   modport slave (
      input  c_addr_i, c_data_i, c_we_i, c_rd_i,
      input  d_addr_i, d_data_i, d_we_i, d_rd_i, d_urgent_i,
      input  data_i, ack_i,
      output c_data_o, c_ack_o, d_data_o, d_ack_o, err_o, grant_o,
      output addr_o, data_o, we_o, rd_o, state_o
   );

   modport master (
      output c_addr_i, c_data_i, c_we_i, c_rd_i,
      output d_addr_i, d_data_i, d_we_i, d_rd_i, d_urgent_i,
      output data_i, ack_i,
      input  c_data_o, c_ack_o, d_data_o, d_ack_o, err_o, grant_o,
      input  addr_o, data_o, we_o, rd_o, state_o
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 256-bit memory port between the CPU path (C) and a device
// master (D). Round-robin between the two, with an urgent override for D and
// a starvation guard that forces C after STARVE_LIMIT consecutive D grants
// while C waits. The winning request is registered onto the memory port and
// a watchdog aborts a grant that sees no ack_i within TIMEOUT cycles.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned TIMEOUT      = 1024
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_C = 2'd1,
      GNT_D = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Watchdog counter only needs to reach TIMEOUT-1.
   localparam int unsigned    TW         = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned    TMO_LAST   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam logic [TW-1:0]  TMO_LAST_V = TW'(TMO_LAST);
   localparam logic [7:0]     STARVE_MAX = 8'(STARVE_LIMIT);

   state_t         state_q, state_d;
   logic           last_q, last_d;       // 1: D won the previous grant
   logic [7:0]     starve_q, starve_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic           err_q, err_d;         // abort cycle in progress
   logic [31:0]    addr_q, addr_d;
   logic [255:0]   data_q, data_d;
   logic           we_q, we_d;
   logic           rd_q, rd_d;
   logic [1:0]     grant_q, grant_d;

   logic           c_req, d_req;
   logic           win_d;                // 1: D wins this arbitration

   assign c_req = bus.c_rd_i | bus.c_we_i;
   assign d_req = bus.d_rd_i | bus.d_we_i;

   // State and registered memory-port outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         starve_q <= '0;
         tmo_q    <= '0;
         err_q    <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         we_q     <= 1'b0;
         rd_q     <= 1'b0;
         grant_q  <= 2'b00;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         starve_q <= starve_d;
         tmo_q    <= tmo_d;
         err_q    <= err_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         we_q     <= we_d;
         rd_q     <= rd_d;
         grant_q  <= grant_d;
      end
   end

   // Arbitration, grant bookkeeping, completion and watchdog abort.
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      starve_d = starve_q;
      tmo_d    = tmo_q;
      err_d    = err_q;
      addr_d   = addr_q;
      data_d   = data_q;
      we_d     = we_q;
      rd_d     = rd_q;
      grant_d  = grant_q;
      win_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (c_req || d_req) begin
               if (!c_req)                     win_d = 1'b1;
               else if (!d_req)                win_d = 1'b0;
               else if (starve_q == STARVE_MAX) win_d = 1'b0;
               else if (bus.d_urgent_i)        win_d = 1'b1;
               else                            win_d = ~last_q;

               last_d = win_d;
               tmo_d  = '0;
               if (win_d) begin
                  state_d  = GNT_D;
                  addr_d   = bus.d_addr_i;
                  data_d   = bus.d_data_i;
                  we_d     = bus.d_we_i;
                  rd_d     = bus.d_rd_i & ~bus.d_we_i;   // rd+we acts as a write
                  grant_d  = 2'b10;
                  if (c_req)
                     starve_d = (starve_q == 8'hFF) ? starve_q : starve_q + 8'd1;
                  else
                     starve_d = '0;
               end else begin
                  state_d  = GNT_C;
                  addr_d   = bus.c_addr_i;
                  data_d   = bus.c_data_i;
                  we_d     = bus.c_we_i;
                  rd_d     = bus.c_rd_i & ~bus.c_we_i;
                  grant_d  = 2'b01;
                  starve_d = '0;
               end
            end
         end

         GNT_C, GNT_D: begin
            if (err_q) begin
               // Abort pulse has been shown for one cycle; release the port.
               err_d   = 1'b0;
               grant_d = 2'b00;
               state_d = DONE;
            end else if (bus.ack_i) begin
               // A real ack beats a watchdog expiry in the same cycle.
               rd_d    = 1'b0;
               we_d    = 1'b0;
               grant_d = 2'b00;
               state_d = DONE;
            end else if (TIMEOUT != 0) begin
               if (tmo_q == TMO_LAST_V) begin
                  err_d = 1'b1;
                  rd_d  = 1'b0;
                  we_d  = 1'b0;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
         end

         DONE: state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   // Completion pulses: a live ack from memory, or the registered abort.
   assign bus.c_ack_o  = (state_q == GNT_C) && (err_q || bus.ack_i);
   assign bus.d_ack_o  = (state_q == GNT_D) && (err_q || bus.ack_i);
   assign bus.err_o    = err_q;
   assign bus.c_data_o = bus.data_i;
   assign bus.d_data_o = bus.data_i;
   assign bus.grant_o  = grant_q;
   assign bus.addr_o   = addr_q;
   assign bus.data_o   = data_q;
   assign bus.we_o     = we_q;
   assign bus.rd_o     = rd_q;
   assign bus.state_o  = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two requester drivers, a memory responder,
// a grant/ack monitor with an expected-grant queue, a table of arbitration
// vectors and hand-written multi-cycle sequences.
module tb_mem_port_arbiter;
   localparam int W = 292;   // {grant[1:0], we, rd, addr[31:0], data[255:0]}

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if bus();

   mem_port_arbiter #(.STARVE_LIMIT(8), .TIMEOUT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];

   // Requester control (written by main, read by drivers).
   int           c_target = 0, d_target = 0;
   logic         c_op_rd = 1'b0, c_op_we = 1'b0, d_op_rd = 1'b0, d_op_we = 1'b0;
   logic [31:0]  c_base = '0, d_base = '0;
   logic [255:0] c_wdata = {32{8'hA5}};
   logic [255:0] d_wdata = {16{16'hD00D}};
   logic         c_cancel = 1'b0;
   // Driver-owned progress counters.
   int           c_issued = 0, d_issued = 0;
   // Memory responder control.
   int           mem_lat = 2;
   logic         mem_on = 1'b1;
   int           kick_req = 0, kick_done = 0;
   // Monitor state.
   logic         exp_err = 1'b0;
   int           c_ack_n = 0, d_ack_n = 0;

   typedef struct {
      logic       c_rd, c_we, d_rd, d_we, urg;
      int         lat;
      logic [1:0] first, second;
   } vec_t;
   vec_t vt[8];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rec(input logic [1:0] g, input logic we, input logic rd,
                                        input logic [31:0] a, input logic [255:0] d);
      return {g, we, rd & ~we, a, d};
   endfunction

   // Expected grant record for the k-th upcoming transaction of a port.
   function automatic logic [W-1:0] rec_port(input logic [1:0] p, input int k);
      if (p == 2'b01)
         return rec(2'b01, c_op_we, c_op_rd, c_base + 32'((c_issued + k) * 64), c_wdata);
      return rec(2'b10, d_op_we, d_op_rd, d_base + 32'((d_issued + k) * 64), d_wdata);
   endfunction

   task automatic wait_idle(input string name);
      int n = 0;
      while ((c_issued < c_target || d_issued < d_target) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(name, n < 2000, 1'b1);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_grant(input string name, input logic [1:0] g);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.grant_o != g && n < 50);
      chk(name, bus.grant_o, g);
   endtask

   // C requester: holds its request until c_ack_o, drops it the next cycle.
   initial begin : c_driver
      int waited;
      bus.c_rd_i = 1'b0; bus.c_we_i = 1'b0; bus.c_addr_i = '0; bus.c_data_i = '0;
      forever begin
         @(posedge clk); #1;
         if (c_issued < c_target) begin
            bus.c_addr_i = c_base + 32'(c_issued * 64);
            bus.c_data_i = c_wdata;
            bus.c_rd_i   = c_op_rd;
            bus.c_we_i   = c_op_we;
            waited = 0;
            do begin
               @(negedge clk);
               waited++;
            end while (!bus.c_ack_o && !c_cancel && waited < 300);
            if (c_cancel) begin
               bus.c_rd_i = 1'b0; bus.c_we_i = 1'b0;
            end else begin
               chk("c_ack_wait", waited < 300, 1'b1);
               @(posedge clk); #1;
               bus.c_rd_i = 1'b0; bus.c_we_i = 1'b0;
            end
            c_issued++;
         end
      end
   end

   // D requester, same protocol.
   initial begin : d_driver
      int waited;
      bus.d_rd_i = 1'b0; bus.d_we_i = 1'b0; bus.d_addr_i = '0; bus.d_data_i = '0;
      forever begin
         @(posedge clk); #1;
         if (d_issued < d_target) begin
            bus.d_addr_i = d_base + 32'(d_issued * 64);
            bus.d_data_i = d_wdata;
            bus.d_rd_i   = d_op_rd;
            bus.d_we_i   = d_op_we;
            waited = 0;
            do begin
               @(negedge clk);
               waited++;
            end while (!bus.d_ack_o && waited < 300);
            chk("d_ack_wait", waited < 300, 1'b1);
            @(posedge clk); #1;
            bus.d_rd_i = 1'b0; bus.d_we_i = 1'b0;
            d_issued++;
         end
      end
   end

   // Memory: acks mem_lat cycles into a strobe; a kick forces one stray ack.
   initial begin : mem_model
      int cnt;
      cnt = 0;
      bus.ack_i = 1'b0; bus.data_i = '0;
      forever begin
         @(posedge clk); #1;
         bus.ack_i = 1'b0;
         if (kick_req != kick_done) begin
            kick_done  = kick_req;
            bus.ack_i  = 1'b1;
            bus.data_i = {8{32'hBAD0_0000}};
         end else if (mem_on && (bus.rd_o || bus.we_o)) begin
            cnt++;
            if (cnt >= mem_lat) begin
               bus.ack_i  = 1'b1;
               bus.data_i = {8{bus.addr_o ^ 32'h3C3C_0000}};
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Monitor: each new grant pops the expected queue; acks are checked.
   initial begin : monitor
      logic [1:0]   prev_g;
      logic [W-1:0] e;
      prev_g = 2'b00;
      forever begin
         @(negedge clk);
         if (bus.grant_o != 2'b00 && prev_g == 2'b00) begin
            if (exp_q.size() == 0) begin
               chk("grant_unexpected", bus.grant_o, 2'b00);
            end else begin
               e = exp_q.pop_front();
               chk("grant_port", bus.grant_o, e[291:290]);
               chk("grant_we",   bus.we_o,    e[289]);
               chk("grant_rd",   bus.rd_o,    e[288]);
               chk("grant_addr", bus.addr_o,  e[287:256]);
               chk("grant_data", bus.data_o,  e[255:0]);
            end
         end
         prev_g = bus.grant_o;
         if (bus.c_ack_o || bus.d_ack_o) begin
            chk("ack_err", bus.err_o, exp_err);
            chk("ack_exclusive", bus.c_ack_o & bus.d_ack_o, 1'b0);
            if (bus.c_ack_o) begin
               c_ack_n++;
               chk("c_ack_owner", bus.grant_o, 2'b01);
               if (!bus.err_o) chk("c_data_o", bus.c_data_o, bus.data_i);
            end
            if (bus.d_ack_o) begin
               d_ack_n++;
               chk("d_ack_owner", bus.grant_o, 2'b10);
               if (!bus.err_o) chk("d_data_o", bus.d_data_o, bus.data_i);
            end
         end
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog simulation time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin : main
      int n, rd_cnt, c0, d0;
      vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 2'b01, 2'b00};
      vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 2'b10, 2'b00};
      vt[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 2'b01, 2'b10};
      vt[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2, 2'b10, 2'b01};
      vt[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3, 2'b10, 2'b01};
      vt[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2, 2'b10, 2'b01};
      vt[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 2'b10, 2'b00};
      vt[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 2'b01, 2'b10};

      bus.d_urgent_i = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_grant", bus.grant_o, 2'b00);
      chk("rst_rd",    bus.rd_o,    1'b0);
      chk("rst_we",    bus.we_o,    1'b0);
      chk("rst_err",   bus.err_o,   1'b0);
      chk("rst_addr",  bus.addr_o,  32'h0);
      chk("rst_data",  bus.data_o,  256'h0);
      chk("rst_acks",  {bus.c_ack_o, bus.d_ack_o}, 2'b00);
      chk("rst_state", bus.state_o, 2'd0);

      // Single C read of 0x1000, memory acks on the 4th strobe cycle.
      mem_lat = 4; c_op_rd = 1'b1; c_op_we = 1'b0; c_base = 32'h0000_1000;
      exp_q.push_back(rec_port(2'b01, 0));
      c_target++;
      wait_grant("c_read_grant", 2'b01);
      rd_cnt = 0; n = 0;
      while (n < 40) begin
         if (bus.rd_o) rd_cnt++;
         if (bus.c_ack_o) break;
         @(negedge clk);
         n++;
      end
      chk("c_read_rd_cycles", rd_cnt, 4);
      chk("c_read_ack", bus.c_ack_o, 1'b1);
      @(negedge clk);
      chk("c_read_ack_once", bus.c_ack_o, 1'b0);
      chk("c_read_grant_off", bus.grant_o, 2'b00);
      chk("c_read_no_d_ack", d_ack_n, 0);
      wait_idle("c_read_done");

      // Reset two cycles into a C read, then a stray ack.
      mem_on = 1'b0; c_base = 32'h0000_2000;
      exp_q.push_back(rec_port(2'b01, 0));
      c_target++;
      wait_grant("rstmid_grant", 2'b01);
      @(negedge clk);
      rst = 1'b1; c_cancel = 1'b1;
      @(negedge clk);
      chk("rstmid_rd",    bus.rd_o,    1'b0);
      chk("rstmid_grant_off", bus.grant_o, 2'b00);
      chk("rstmid_addr",  bus.addr_o,  32'h0);
      rst = 1'b0;
      c0 = c_ack_n;
      kick_req++;
      repeat (5) @(negedge clk);
      chk("rstmid_no_c_ack", c_ack_n, c0);
      chk("rstmid_idle", bus.grant_o, 2'b00);
      c_cancel = 1'b0; mem_on = 1'b1;
      wait_idle("rstmid_done");

      // Both request continuously after reset: C, D, C, D.
      mem_lat = 2; c_op_rd = 1'b1; c_op_we = 1'b0; d_op_rd = 1'b1; d_op_we = 1'b0;
      c_base = 32'h0000_3000; d_base = 32'h8000_3000;
      c0 = c_ack_n; d0 = d_ack_n;
      exp_q.push_back(rec_port(2'b01, 0));
      exp_q.push_back(rec_port(2'b10, 0));
      exp_q.push_back(rec_port(2'b01, 1));
      exp_q.push_back(rec_port(2'b10, 1));
      c_target += 2; d_target += 2;
      wait_idle("rr_done");
      chk("rr_queue_empty", exp_q.size(), 0);
      chk("rr_c_acks", c_ack_n - c0, 2);
      chk("rr_d_acks", d_ack_n - d0, 2);

      // Arbitration vector table.
      for (int i = 0; i < 8; i++) begin
         c_op_rd = vt[i].c_rd; c_op_we = vt[i].c_we;
         d_op_rd = vt[i].d_rd; d_op_we = vt[i].d_we;
         bus.d_urgent_i = vt[i].urg;
         mem_lat = vt[i].lat;
         c_base = 32'h0001_0000 + 32'(i * 256);
         d_base = 32'h8001_0000 + 32'(i * 256);
         c0 = c_ack_n; d0 = d_ack_n;
         exp_q.push_back(rec_port(vt[i].first, 0));
         if (vt[i].second != 2'b00) exp_q.push_back(rec_port(vt[i].second, 0));
         if (vt[i].c_rd || vt[i].c_we) c_target++;
         if (vt[i].d_rd || vt[i].d_we) d_target++;
         wait_idle("vec_done");
         chk("vec_queue_empty", exp_q.size(), 0);
         chk("vec_c_acks", c_ack_n - c0, 32'(vt[i].c_rd | vt[i].c_we));
         chk("vec_d_acks", d_ack_n - d0, 32'(vt[i].d_rd | vt[i].d_we));
      end

      // Urgent D with C pending: 8 D grants, one forced C, then D again.
      bus.d_urgent_i = 1'b1; mem_lat = 1;
      c_op_rd = 1'b1; c_op_we = 1'b0; d_op_rd = 1'b1; d_op_we = 1'b0;
      c_base = 32'h0002_0000; d_base = 32'h8002_0000;
      for (int k = 0; k < 8; k++) exp_q.push_back(rec_port(2'b10, k));
      exp_q.push_back(rec_port(2'b01, 0));
      exp_q.push_back(rec_port(2'b10, 8));
      exp_q.push_back(rec_port(2'b10, 9));
      c_target += 1; d_target += 10;
      wait_idle("starve_done");
      chk("starve_queue_empty", exp_q.size(), 0);
      bus.d_urgent_i = 1'b0;

      // Memory never acks a D write: abort 17 cycles after the grant.
      mem_on = 1'b0; exp_err = 1'b1;
      d_op_rd = 1'b0; d_op_we = 1'b1; d_base = 32'h8003_0000;
      d0 = d_ack_n;
      exp_q.push_back(rec_port(2'b10, 0));
      d_target++;
      wait_grant("tmo_grant", 2'b10);
      n = 1;
      while (!bus.d_ack_o && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_ack_cycle", n, 17);
      chk("tmo_err", bus.err_o, 1'b1);
      chk("tmo_we_dropped", bus.we_o, 1'b0);
      @(negedge clk);
      chk("tmo_ack_once", bus.d_ack_o, 1'b0);
      chk("tmo_err_once", bus.err_o, 1'b0);
      chk("tmo_grant_off", bus.grant_o, 2'b00);
      exp_err = 1'b0; mem_on = 1'b1;
      wait_idle("tmo_done");
      chk("tmo_d_acks", d_ack_n - d0, 1);

      chk("final_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
